// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the matching transmitter.
// UART_RX_PARITY_EN adds the PARITY receive state.
package uart_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_IDLE      = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_8n1.sv
// UART receiver: 8N1 by default, 8E1 with PARITY_ERR when UART_RX_PARITY_EN is defined.
// Samples mid-bit using a counter restarted at the start edge.
//
// state  | meaning
// IDLE   | line idle, waiting for a low level
// START  | half a bit in, confirm the start bit is still low
// DATA   | sample 8 data bits, LSB first
// PARITY | sample even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sample stop bit, emit VALID / PARITY_ERR / FRAME_ERR
// BREAK  | stop bit was low, wait for the line to go high again
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD        = 115_200
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      RXD,
  output logic [UART_DATA_BITS-1:0] DATA,
  output logic                      VALID,
  output logic                      FRAME_ERR,
`ifdef UART_RX_PARITY_EN
  output logic                      PARITY_ERR,
`endif
  output logic                      BUSY
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int BW           = $clog2(UART_DATA_BITS);

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_cpb_check
      $error("uart_rx_8n1: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  uart_rx_state_t            r_state, w_state_nxt;
  logic [CW-1:0]             r_cnt,   w_cnt_nxt;
  logic [BW-1:0]             r_bit,   w_bit_nxt;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [UART_DATA_BITS-1:0] r_data,  w_data_nxt;
  logic                      r_valid, w_valid_nxt;
  logic                      r_ferr,  w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
  logic                      r_perr,    w_perr_nxt;
  logic                      r_par_bad, w_par_bad_nxt;
`endif
  logic                      w_rxs;

  sync_2ff #(
    .RESET_VAL (UART_IDLE)
  ) u_sync (
    .i_clk (CLK),
    .i_rst (RESET),
    .i_d   (RXD),
    .o_q   (w_rxs)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr    <= 1'b0;
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
      r_perr    <= w_perr_nxt;
      r_par_bad <= w_par_bad_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr_nxt    = 1'b0;
    w_par_bad_nxt = r_par_bad;
`endif

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rxs != UART_IDLE) w_state_nxt = ST_START;
      end

      ST_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt = '0;
          w_bit_nxt = '0;
          w_state_nxt = (w_rxs == UART_IDLE) ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rxs, r_shift[UART_DATA_BITS-1:1]};
          if (r_bit == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_nxt     = '0;
          w_par_bad_nxt = ^{r_shift, w_rxs};
          w_state_nxt   = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_nxt = '0;
          if (w_rxs == UART_IDLE) begin
            w_state_nxt = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (r_par_bad) begin
              w_perr_nxt = 1'b1;
            end else begin
              w_valid_nxt = 1'b1;
              w_data_nxt  = r_shift;
            end
`else
            w_valid_nxt = 1'b1;
            w_data_nxt  = r_shift;
`endif
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = ST_BREAK;
          end
        end
      end

      ST_BREAK: begin
        w_cnt_nxt = '0;
        if (w_rxs == UART_IDLE) w_state_nxt = ST_IDLE;
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign DATA      = r_data;
  assign VALID     = r_valid;
  assign FRAME_ERR = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR = r_perr;
`endif
  assign BUSY      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1 at 16 clocks per bit; covers the parity
// build too when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_8n1;

  localparam int CPB = 16;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       RXD = 1'b1;
  logic [7:0] DATA;
  logic       VALID;
  logic       FRAME_ERR;
  logic       BUSY;
`ifdef UART_RX_PARITY_EN
  logic       PARITY_ERR;
  int         perr_n = 0;
`endif

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] got_q[$];
  int         ferr_n = 0;
  int         glitch_n = 0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] last_data = 8'h00;

  uart_rx_8n1 #(
    .CLK_FREQ_HZ (1_600_000),
    .BAUD        (100_000)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .RXD        (RXD),
    .DATA       (DATA),
    .VALID      (VALID),
    .FRAME_ERR  (FRAME_ERR),
`ifdef UART_RX_PARITY_EN
    .PARITY_ERR (PARITY_ERR),
`endif
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  // Event recorder: pulses are sampled on the falling edge, one entry per high cycle.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (VALID) got_q.push_back(DATA);
      if (FRAME_ERR) ferr_n <= ferr_n + 1;
`ifdef UART_RX_PARITY_EN
      if (PARITY_ERR) perr_n <= perr_n + 1;
`endif
      if (DATA !== prev_data && !VALID) glitch_n <= glitch_n + 1;
    end
    prev_data <= DATA;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    RXD = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    RXD = (^b) ^ par_flip;
    tick(CPB);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    RXD = stop_bit;
    tick(CPB);
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    RXD = 1'b1;
    tick(3);
    RESET = 1'b0;
    tick(3);
    n_vec++; if (DATA !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", DATA); end
    n_vec++; if (VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", VALID); end
    n_vec++; if (FRAME_ERR !== 1'b0) begin n_err++; $display("FAIL reset_ferr got %b want 0", FRAME_ERR); end
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", BUSY); end
`ifdef UART_RX_PARITY_EN
    n_vec++; if (PARITY_ERR !== 1'b0) begin n_err++; $display("FAIL reset_perr got %b want 0", PARITY_ERR); end
`endif
    last_data = 8'h00;
  endtask

  task automatic test_single;
    int n0, f0;
    n0 = got_q.size();
    f0 = ferr_n;
    send_frame(8'hA5, 1'b1, 1'b0);
    RXD = 1'b1;
    tick(CPB);
    last_data = 8'hA5;
    n_vec++; if (got_q.size() - n0 != 1) begin n_err++; $display("FAIL single_count got %0d want 1", got_q.size() - n0); end
    if (got_q.size() > n0) begin
      n_vec++; if (got_q[n0] !== 8'hA5) begin n_err++; $display("FAIL single_data got %h want a5", got_q[n0]); end
    end
    n_vec++; if (DATA !== last_data) begin n_err++; $display("FAIL single_hold got %h want %h", DATA, last_data); end
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL single_busy got %b want 0", BUSY); end
    n_vec++; if (ferr_n - f0 != 0) begin n_err++; $display("FAIL single_ferr got %0d want 0", ferr_n - f0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q[$];
    int n0;
    exp_q = '{8'h00, 8'hFF, 8'h3C};
    n0 = got_q.size();
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, 1'b0);
    RXD = 1'b1;
    tick(CPB);
    last_data = exp_q[exp_q.size()-1];
    n_vec++; if (got_q.size() - n0 != exp_q.size()) begin n_err++; $display("FAIL b2b_count got %0d want %0d", got_q.size() - n0, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got_q.size() > n0 + i) begin
        n_vec++; if (got_q[n0+i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", i, got_q[n0+i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_glitch;
    int n0, f0;
    n0 = got_q.size();
    f0 = ferr_n;
    RXD = 1'b0;
    tick(5);
    RXD = 1'b1;
    tick(3 * CPB);
    n_vec++; if (got_q.size() != n0) begin n_err++; $display("FAIL glitch_valid got %0d want 0", got_q.size() - n0); end
    n_vec++; if (ferr_n != f0) begin n_err++; $display("FAIL glitch_ferr got %0d want 0", ferr_n - f0); end
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL glitch_busy got %b want 0", BUSY); end
  endtask

  task automatic test_frame_err;
    int n0, f0;
    n0 = got_q.size();
    f0 = ferr_n;
    send_frame(8'h55, 1'b0, 1'b0);
    RXD = 1'b0;
    tick(40 * CPB);
    n_vec++; if (ferr_n - f0 != 1) begin n_err++; $display("FAIL ferr_count got %0d want 1", ferr_n - f0); end
    n_vec++; if (got_q.size() != n0) begin n_err++; $display("FAIL ferr_valid got %0d want 0", got_q.size() - n0); end
    n_vec++; if (DATA !== last_data) begin n_err++; $display("FAIL ferr_data got %h want %h", DATA, last_data); end
    n_vec++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL ferr_busy_low got %b want 1", BUSY); end
    RXD = 1'b1;
    tick(5);
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL ferr_busy_release got %b want 0", BUSY); end
    tick(CPB);
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    int n0, f0;
    b = 8'h81;
    n0 = got_q.size();
    f0 = ferr_n;
    RXD = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      RXD = b[i];
      tick(CPB);
    end
    RXD = b[4];
    tick(CPB / 2);
    RESET = 1'b1;
    tick(2);
    n_vec++; if (DATA !== 8'h00) begin n_err++; $display("FAIL rstmid_data got %h want 00", DATA); end
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", BUSY); end
    n_vec++; if (VALID !== 1'b0 || FRAME_ERR !== 1'b0) begin n_err++; $display("FAIL rstmid_pulse got %b%b want 00", VALID, FRAME_ERR); end
    RXD = 1'b1;
    tick(4);
    RESET = 1'b0;
    last_data = 8'h00;
    tick(CPB * 6);
    n_vec++; if (got_q.size() != n0 || ferr_n != f0) begin n_err++; $display("FAIL rstmid_nopulse got %0d/%0d want 0/0", got_q.size() - n0, ferr_n - f0); end
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rstmid_idle got %b want 0", BUSY); end
    send_frame(b, 1'b1, 1'b0);
    RXD = 1'b1;
    tick(CPB);
    last_data = b;
    n_vec++; if (got_q.size() - n0 != 1) begin n_err++; $display("FAIL rstmid_refr_count got %0d want 1", got_q.size() - n0); end
    n_vec++; if (DATA !== b) begin n_err++; $display("FAIL rstmid_refr_data got %h want %h", DATA, b); end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int n0, f0, gap;
    n0 = got_q.size();
    f0 = ferr_n;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1, 1'b0);
      RXD = 1'b1;
      gap = (i % 3 == 0) ? 0 : int'($urandom_range(1, 2 * CPB));
      if (gap > 0) tick(gap);
    end
    RXD = 1'b1;
    tick(CPB);
    last_data = exp_q[exp_q.size()-1];
    n_vec++; if (got_q.size() - n0 != exp_q.size()) begin n_err++; $display("FAIL rand_count got %0d want %0d", got_q.size() - n0, exp_q.size()); end
    n_vec++; if (ferr_n != f0) begin n_err++; $display("FAIL rand_ferr got %0d want 0", ferr_n - f0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got_q.size() > n0 + i) begin
        n_vec++; if (got_q[n0+i] !== exp_q[i]) begin n_err++; $display("FAIL rand_data[%0d] got %h want %h", i, got_q[n0+i], exp_q[i]); end
      end
    end
    n_vec++; if (DATA !== last_data) begin n_err++; $display("FAIL rand_hold got %h want %h", DATA, last_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int n0, p0;
    n0 = got_q.size();
    p0 = perr_n;
    send_frame(8'h07, 1'b1, 1'b0);
    RXD = 1'b1;
    tick(CPB);
    last_data = 8'h07;
    n_vec++; if (got_q.size() - n0 != 1) begin n_err++; $display("FAIL par_ok_count got %0d want 1", got_q.size() - n0); end
    n_vec++; if (DATA !== 8'h07) begin n_err++; $display("FAIL par_ok_data got %h want 07", DATA); end
    n_vec++; if (perr_n != p0) begin n_err++; $display("FAIL par_ok_perr got %0d want 0", perr_n - p0); end
    send_frame(8'h07, 1'b1, 1'b1);
    RXD = 1'b1;
    tick(CPB);
    n_vec++; if (perr_n - p0 != 1) begin n_err++; $display("FAIL par_bad_perr got %0d want 1", perr_n - p0); end
    n_vec++; if (got_q.size() - n0 != 1) begin n_err++; $display("FAIL par_bad_valid got %0d want 1", got_q.size() - n0); end
    n_vec++; if (DATA !== last_data) begin n_err++; $display("FAIL par_bad_data got %h want %h", DATA, last_data); end
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL par_bad_busy got %b want 0", BUSY); end
  endtask
`endif

  task automatic test_data_stable;
    n_vec++; if (glitch_n != 0) begin n_err++; $display("FAIL data_stable got %0d changes without VALID want 0", glitch_n); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_data_stable();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
